// File: rtl/singleton_count_merge.sv
// Singleton-count merge: queues each graph's singleton count until the explorer finishes, then emits explorer count + singleton count.
// Optional sticky overflow/underflow flags are compiled in when SINGLETON_MERGE_CHECK_EN is defined.
module singleton_count_merge #(
    parameter int DEPTH     = 16,
    parameter int COUNT_LAG = 4,
    parameter int SLACK     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     graphValidIn,
    input  logic [5:0]               singletonCount,
    input  logic                     explorerDone,
    input  logic [5:0]               connectCount,
    output logic                     totalValid,
    output logic [6:0]               totalCount,
    output logic                     almostFull,
    output logic [$clog2(DEPTH):0]   pending
`ifdef SINGLETON_MERGE_CHECK_EN
    ,
    output logic                     errOverflow,
    output logic                     errUnderflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LEVEL = (AW + 1)'(DEPTH - SLACK);

    logic [COUNT_LAG-1:0] lagPipe;
    logic [5:0]           fifoMem [DEPTH];
    logic [AW:0]          wrPtr;
    logic [AW:0]          rdPtr;
    logic [AW:0]          pendingNext;
    logic                 pushReq;
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic                 doPush;
    logic                 doPop;
    logic [5:0]           headData;

    assign pushReq   = lagPipe[COUNT_LAG-1];
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop     = explorerDone && !fifoEmpty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
    assign doPush    = pushReq && (!fifoFull || doPop);
    assign headData  = fifoEmpty ? 6'd0 : fifoMem[rdPtr[AW-1:0]];

    always_comb begin
        pendingNext = pending;
        if (graphValidIn && !explorerDone) begin
            if (pending != '1) pendingNext = pending + (AW + 1)'(1);
        end else if (!graphValidIn && explorerDone) begin
            if (pending != '0) pendingNext = pending - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lagPipe    <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            pending    <= '0;
            almostFull <= 1'b0;
            totalValid <= 1'b0;
            totalCount <= 7'd0;
        end else begin
            lagPipe    <= (lagPipe << 1) | COUNT_LAG'(graphValidIn);
            pending    <= pendingNext;
            almostFull <= (pendingNext >= AF_LEVEL);
            totalValid <= explorerDone;
            if (doPush) wrPtr <= wrPtr + (AW + 1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW + 1)'(1);
            if (explorerDone) totalCount <= {1'b0, headData} + {1'b0, connectCount};
        end
    end

    // Storage is deliberately left unreset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (doPush) fifoMem[wrPtr[AW-1:0]] <= singletonCount;
    end

`ifdef SINGLETON_MERGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errOverflow  <= 1'b0;
            errUnderflow <= 1'b0;
        end else begin
            if (pushReq && !doPush)       errOverflow  <= 1'b1;
            if (explorerDone && fifoEmpty) errUnderflow <= 1'b1;
        end
    end
`else
    // Without checks, dropped pushes and empty pops are silent; the data path is identical.
`endif

endmodule

// File: tb/tb_singleton_count_merge.sv
// Scoreboard bench for singleton_count_merge: directed graph streams with hand-computed totals.
module tb_singleton_count_merge;

    localparam int DEPTH = 16;
    localparam int LAG   = 4;
    localparam int SLACK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       graphValidIn = 1'b0;
    logic [5:0] singletonCount = 6'd0;
    logic       explorerDone = 1'b0;
    logic [5:0] connectCount = 6'd0;
    logic       totalValid;
    logic [6:0] totalCount;
    logic       almostFull;
    logic [4:0] pending;
`ifdef SINGLETON_MERGE_CHECK_EN
    logic       errOverflow;
    logic       errUnderflow;
`endif

    singleton_count_merge #(.DEPTH(DEPTH), .COUNT_LAG(LAG), .SLACK(SLACK)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .graphValidIn(graphValidIn),
        .singletonCount(singletonCount),
        .explorerDone(explorerDone),
        .connectCount(connectCount),
        .totalValid(totalValid),
        .totalCount(totalCount),
        .almostFull(almostFull),
        .pending(pending)
`ifdef SINGLETON_MERGE_CHECK_EN
        ,
        .errOverflow(errOverflow),
        .errUnderflow(errUnderflow)
`endif
    );

    always #5 clk = ~clk;

    int         nChecks = 0;
    int         nPass = 0;
    int         pendExp = 0;
    logic [6:0] expQ [$];
    logic [5:0] scDelay [LAG];
    logic       lastDone;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle of upstream/explorer stimulus; singletonCount is replayed LAG cycles after its graph.
    task automatic cycle(input logic gv, input int sc, input logic ed, input int cc, input int expTot);
        graphValidIn   = gv;
        explorerDone   = ed;
        connectCount   = 6'(cc);
        singletonCount = scDelay[LAG-1];
        for (int i = LAG - 1; i > 0; i--) scDelay[i] = scDelay[i-1];
        scDelay[0] = gv ? 6'(sc) : 6'h2A;
        if (ed) expQ.push_back(7'(expTot));
        if (gv && !ed) pendExp++;
        else if (!gv && ed && pendExp > 0) pendExp--;
        @(posedge clk);
        #1;
        chk("pending", int'(pending), pendExp);
        chk("almostFull", int'(almostFull), int'(pendExp >= DEPTH - SLACK));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 1'b0, 0, 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lastDone <= 1'b0;
        else        lastDone <= explorerDone;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (totalValid || lastDone) chk("totalValid latency", int'(totalValid), int'(lastDone));
            if (totalValid) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("FAIL unexpected total: got totalCount %0d, expected no output", totalCount);
                end else begin
                    chk("totalCount", int'(totalCount), int'(expQ.pop_front()));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < LAG; i++) scDelay[i] = 6'h2A;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pending", int'(pending), 0);
        chk("reset totalValid", int'(totalValid), 0);
        chk("reset totalCount", int'(totalCount), 0);
        chk("reset almostFull", int'(almostFull), 0);
`ifdef SINGLETON_MERGE_CHECK_EN
        chk("reset errOverflow", int'(errOverflow), 0);
        chk("reset errUnderflow", int'(errUnderflow), 0);
`endif
        rst_n = 1'b1;

        // Single graph: count 5, explorer count 3 ten cycles later.
        cycle(1'b1, 5, 1'b0, 0, 0);
        idle(9);
        cycle(1'b0, 0, 1'b1, 3, 8);
        idle(3);

        // Back-to-back stream of 16 graphs, explorer 20 cycles behind.
        for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b0, 0, 0);
        idle(4);
        for (int i = 0; i < 16; i++) cycle(1'b0, 0, 1'b1, 1, i + 1);
        idle(3);

        // Steady push+pop at occupancy 3; read pointer crosses 15 -> 0.
        for (int k = 0; k < 27; k++)
            cycle(k < 20, 10 + k, k >= 7, 2, 12 + (k - 7));
        idle(3);

        // Overflow: 17 pushes, no pops; 17th count (36) must vanish.
        for (int i = 0; i < 17; i++) cycle(1'b1, 20 + i, 1'b0, 0, 0);
        idle(5);
`ifdef SINGLETON_MERGE_CHECK_EN
        chk("errOverflow set", int'(errOverflow), 1);
        chk("errUnderflow clear", int'(errUnderflow), 0);
`endif
        for (int i = 0; i < 16; i++) cycle(1'b0, 0, 1'b1, 5, 25 + i);
        cycle(1'b0, 0, 1'b1, 5, 5);
`ifdef SINGLETON_MERGE_CHECK_EN
        chk("errUnderflow set", int'(errUnderflow), 1);
`endif
        idle(2);

        // Explicit underflow, then confirm the read pointer held.
        cycle(1'b0, 0, 1'b1, 9, 9);
        cycle(1'b1, 7, 1'b0, 0, 0);
        idle(4);
        cycle(1'b0, 0, 1'b1, 1, 8);
        idle(3);

        // Reset with 5 graphs pending.
        for (int i = 0; i < 5; i++) cycle(1'b1, 40 + i, 1'b0, 0, 0);
        chk("pending before reset", int'(pending), 5);
        #2;
        rst_n = 1'b0;
        graphValidIn = 1'b0;
        #1;
        chk("async reset pending", int'(pending), 0);
        chk("async reset totalValid", int'(totalValid), 0);
        chk("async reset totalCount", int'(totalCount), 0);
        chk("async reset almostFull", int'(almostFull), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pendExp = 0;
        for (int i = 0; i < LAG; i++) scDelay[i] = 6'h2A;
`ifdef SINGLETON_MERGE_CHECK_EN
        chk("errOverflow cleared", int'(errOverflow), 0);
        chk("errUnderflow cleared", int'(errUnderflow), 0);
`endif
        idle(2);
        cycle(1'b0, 0, 1'b1, 4, 4);
        cycle(1'b1, 3, 1'b0, 0, 0);
        idle(4);
        cycle(1'b0, 0, 1'b1, 3, 6);
        idle(3);
`ifdef SINGLETON_MERGE_CHECK_EN
        chk("errUnderflow after reset", int'(errUnderflow), 1);
`endif

        chk("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/singleton_count_merge.md
# singleton_count_merge

Receiving end of the singleton-elimination stage. It captures each graph's 6-bit singleton count when that count emerges, 4 cycles after the graph's `nonSingletons` are presented. It holds the count in an in-order FIFO while the graph runs through the variable-latency connected-component explorer. When the explorer finishes, it emits the final component total: explorer count plus singleton count. It sits between the elimination stage and the result collector of the pipelined count-connected core.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `COUNT_LAG`, 4: cycles from `graphValidIn` to a valid `singletonCount`.
- `SLACK`, 2: `almostFull` asserts at `pending ≥ DEPTH − SLACK`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `graphValidIn`  in  1: a graph's `nonSingletons` is handed to the explorer this cycle.
- `singletonCount`  in  6: singleton count from the elimination stage, valid `COUNT_LAG` cycles after `graphValidIn`.
- `explorerDone`  in  1: the explorer has finished the oldest outstanding graph. Graphs complete in order.
- `connectCount`  in  6: component count of non-singleton vertices, valid with `explorerDone`.
- `totalValid`  out  1: one-cycle pulse per completed graph.
- `totalCount`  out  7: `connectCount + singletonCount`, zero-extended.
- `almostFull`  out  1: upstream must stop asserting `graphValidIn`.
- `pending`  out  log2(DEPTH)+1: graphs accepted and not yet popped.
- `errOverflow`  out  1: sticky; only present if `SINGLETON_MERGE_CHECK_EN` is defined.
- `errUnderflow`  out  1: sticky; only present if `SINGLETON_MERGE_CHECK_EN` is defined.

## Operation
- Delay pipe: a `COUNT_LAG`-deep shift register carries `graphValidIn`.
  - When its tail bit is 1, `singletonCount` is sampled and pushed at the FIFO write pointer.
  - The delay pipe carries only the valid bit, never data.
- FIFO: circular buffer with `DEPTH` entries of 6 bits.
  - Write and read pointers wrap modulo `DEPTH`.
  - Full/empty use an extra pointer MSB.
- Pop: on `explorerDone`, the head entry is read and the read pointer advances. On the next edge:
  - `totalCount` ← head + `connectCount`, computed at 7 bits with no overflow (max 126).
  - `totalValid` ← 1.
- `pending`:
  - +1 on `graphValidIn`, −1 on `explorerDone`.
  - Unchanged when both occur in the same cycle.
  - Therefore counts items still in the delay pipe.
- `almostFull` is registered from `pending`. With `SLACK` ≥ 2 this covers the one-cycle reaction delay upstream.
- Simultaneous push and pop on a non-empty FIFO: both are performed and occupancy is unchanged.
- Push with FIFO full: the write is dropped and the pointer holds. `errOverflow` is set if checks are enabled.
- Pop with FIFO empty, including when a push occurs in the same cycle (no bypass):
  - `totalValid` still pulses, with `totalCount = connectCount`.
  - The read pointer holds.
  - `errUnderflow` is set if checks are enabled.
- `graphValidIn` while `almostFull` is high is accepted as long as the FIFO has room. It is a protocol breach upstream but is not flagged.

## Timing
- Reset (asynchronous assert, synchronous release): pointers 0, delay pipe 0, `pending` 0, `totalValid` 0, `totalCount` 0, `almostFull` 0, error flags 0. FIFO data is not reset.
- Reset mid-operation discards all in-flight counts; the first `explorerDone` after reset is an underflow.
- Push latency: a count enters the FIFO at the edge `COUNT_LAG` cycles after its `graphValidIn` edge.
- Pop latency: `totalValid`/`totalCount` are registered, one cycle after `explorerDone`.
- Minimum explorer latency for underflow-free operation: `explorerDone` no earlier than `COUNT_LAG`+1 cycles after the matching `graphValidIn`.
- Throughput: one push and one pop per cycle.

## Configuration
- `SINGLETON_MERGE_CHECK_EN` defined:
  - Overflow and underflow detection logic is compiled in.
  - `errOverflow`/`errUnderflow` are sticky until reset.
- `SINGLETON_MERGE_CHECK_EN` undefined:
  - The detection logic is absent and the error ports are not declared.
  - Data-path behaviour on overflow/underflow is unchanged: the push is dropped, and an empty pop reads as 0.

## Test plan
- Single graph: `graphValidIn` at cycle 0, `singletonCount`=5 at cycle 4, `explorerDone` with `connectCount`=3 at cycle 10.
  - Required: `totalValid`=1 and `totalCount`=8 at cycle 11; `pending` returns to 0.
- Back-to-back stream: 16 graphs on consecutive cycles with singleton counts 0..15, explorer completes each 20 cycles later with `connectCount`=1.
  - Required: totals 1..16 in order; `almostFull` high while `pending` ≥ 14.
- Simultaneous push and pop at occupancy 3: occupancy stays 3, output value is correct, pointers advance across the wrap from 15 to 0.
- Overflow: 17 pushes with no pops.
  - Required: 17th count dropped, `errOverflow`=1 (if `SINGLETON_MERGE_CHECK_EN`); the first 16 pop unchanged.
- Underflow: `explorerDone` with `connectCount`=9 and an empty FIFO.
  - Required: `totalCount`=9, `errUnderflow`=1, read pointer unchanged.
- Reset mid-stream: `rst_n` low for 2 cycles with 5 pending.
  - Required: all outputs 0 immediately; the subsequent stream behaves as after a fresh reset.
